// File: rtl/mem_bank_group_arbiter.sv
// Narrow/wide bank-group arbiter with anti-starvation wide priority and a response-valid delay line.
// Grants: zero latency; response valids lag grants by RespLat. Ungranted requesters hold their request (valid/ready).
module mem_bank_group_arbiter #(
    parameter int NumNarrowPerWide = 4,
    parameter int MaxWideStall     = 8,
    parameter int MaxWideBurst     = 4,
    parameter int RespLat          = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumNarrowPerWide-1:0] narrow_req_i,
    output logic [NumNarrowPerWide-1:0] narrow_gnt_o,
    input  logic                        wide_req_i,
    output logic                        wide_gnt_o,
    output logic [NumNarrowPerWide-1:0] rsp_narrow_valid_o,
    output logic                        rsp_wide_valid_o,
    output logic                        wide_prio_o,
    output logic [7:0]                  stall_cnt_o
);

    localparam int GntW = NumNarrowPerWide + 1;
    localparam logic [7:0] StallMax = 8'(MaxWideStall);
    localparam logic [7:0] BurstMax = 8'(MaxWideBurst);

    typedef enum logic {
        NARROW_PRIO = 1'b0,
        WIDE_PRIO   = 1'b1
    } state_e;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [7:0]                  r_stall;
    logic [7:0]                  w_stall_nxt;
    logic [7:0]                  r_burst;
    logic [7:0]                  w_burst_nxt;
    logic [NumNarrowPerWide-1:0] w_narrow_gnt;
    logic                        w_wide_gnt;
    logic [GntW-1:0]             w_gnt_vec;
    logic [GntW-1:0]             w_rsp;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= NARROW_PRIO;
            r_stall <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= w_stall_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    always_comb begin
        w_narrow_gnt = '0;
        w_wide_gnt   = 1'b0;
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst;
        w_stall_nxt  = r_stall;

        if (r_state == NARROW_PRIO) begin
            w_narrow_gnt = narrow_req_i;
            w_wide_gnt   = wide_req_i && (narrow_req_i == '0);
        end else begin
            w_wide_gnt   = wide_req_i;
        end

        // A wide grant always clears the stall count, even on the cycle it would saturate.
        if (w_wide_gnt) begin
            w_stall_nxt = '0;
        end else if (wide_req_i && (r_stall < StallMax)) begin
            w_stall_nxt = r_stall + 8'd1;
        end

        case (r_state)
            NARROW_PRIO: begin
                if (w_stall_nxt == StallMax) begin
                    w_state_nxt = WIDE_PRIO;
                    w_burst_nxt = '0;
                end
            end
            WIDE_PRIO: begin
                if (w_wide_gnt) begin
                    w_burst_nxt = r_burst + 8'd1;
                end
                if (!wide_req_i || (w_burst_nxt == BurstMax)) begin
                    w_state_nxt = NARROW_PRIO;
                    w_stall_nxt = '0;
                end
            end
            default: w_state_nxt = NARROW_PRIO;
        endcase
    end

    assign w_gnt_vec = {w_wide_gnt, w_narrow_gnt};

    generate
        if (RespLat == 0) begin : g_no_pipe
            assign w_rsp = w_gnt_vec;
        end else begin : g_pipe
            logic [GntW-1:0] r_pipe [RespLat];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < RespLat; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_gnt_vec;
                    for (int i = 1; i < RespLat; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_rsp = r_pipe[RespLat-1];
        end
    endgenerate

    assign narrow_gnt_o       = w_narrow_gnt;
    assign wide_gnt_o         = w_wide_gnt;
    assign rsp_narrow_valid_o = w_rsp[NumNarrowPerWide-1:0];
    assign rsp_wide_valid_o   = w_rsp[NumNarrowPerWide];
    assign wide_prio_o        = (r_state == WIDE_PRIO);
    assign stall_cnt_o        = r_stall;

endmodule

// File: tb/tb_mem_bank_group_arbiter.sv
// Directed and random checks of mem_bank_group_arbiter at RespLat 1 (main), 0 and 3.
module tb_mem_bank_group_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] narrow_req_i;
    logic       wide_req_i;

    logic [3:0] ngnt1, rspn1, ngnt0, rspn0, ngnt3, rspn3;
    logic       wgnt1, rspw1, prio1, wgnt0, rspw0, prio0, wgnt3, rspw3, prio3;
    logic [7:0] stall1, stall0, stall3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    mem_bank_group_arbiter u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .narrow_req_i(narrow_req_i), .narrow_gnt_o(ngnt1),
        .wide_req_i(wide_req_i), .wide_gnt_o(wgnt1), .rsp_narrow_valid_o(rspn1),
        .rsp_wide_valid_o(rspw1), .wide_prio_o(prio1), .stall_cnt_o(stall1)
    );

    mem_bank_group_arbiter #(.RespLat(0)) u_dut_lat0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .narrow_req_i(narrow_req_i), .narrow_gnt_o(ngnt0),
        .wide_req_i(wide_req_i), .wide_gnt_o(wgnt0), .rsp_narrow_valid_o(rspn0),
        .rsp_wide_valid_o(rspw0), .wide_prio_o(prio0), .stall_cnt_o(stall0)
    );

    mem_bank_group_arbiter #(.RespLat(3)) u_dut_lat3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .narrow_req_i(narrow_req_i), .narrow_gnt_o(ngnt3),
        .wide_req_i(wide_req_i), .wide_gnt_o(wgnt3), .rsp_narrow_valid_o(rspn3),
        .rsp_wide_valid_o(rspw3), .wide_prio_o(prio3), .stall_cnt_o(stall3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic to_sample();
        @(negedge clk_i);
    endtask

    task automatic to_drive();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model state for the random phase
    logic       m_wide;
    logic [7:0] m_stall;
    logic [7:0] m_burst;
    logic       m_wg;
    logic [3:0] m_ng;
    logic [7:0] m_stall_n;
    logic [7:0] m_burst_n;
    logic [4:0] h1;
    logic [4:0] h3 [3];

    initial begin
        rst_ni       = 1'b0;
        narrow_req_i = 4'b0000;
        wide_req_i   = 1'b0;
        to_drive();
        to_sample();
        chk("rst_prio", prio1, 0);
        chk("rst_stall", stall1, 0);
        chk("rst_rsp", {rspw1, rspn1}, 0);
        to_drive();
        rst_ni = 1'b1;

        // Idle narrow traffic
        narrow_req_i = 4'b0101;
        to_sample();
        chk("narrow_gnt", ngnt1, 4'b0101);
        chk("narrow_wgnt", wgnt1, 0);
        chk("narrow_rsp_early", rspn1, 0);
        to_drive();
        narrow_req_i = 4'b0000;
        to_sample();
        chk("narrow_rsp_lat1", rspn1, 4'b0101);
        chk("narrow_gnt_drop", ngnt1, 0);
        to_drive();
        to_sample();
        chk("narrow_rsp_clear", rspn1, 0);
        to_drive();

        // Wide alone
        wide_req_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            to_sample();
            chk("wide_alone_gnt", wgnt1, 1);
            chk("wide_alone_stall", stall1, 0);
            chk("wide_alone_prio", prio1, 0);
            if (i > 0) chk("wide_alone_rsp", rspw1, 1);
            to_drive();
        end
        wide_req_i = 1'b0;
        to_sample();
        chk("wide_alone_gnt_off", wgnt1, 0);
        chk("wide_alone_rsp_tail", rspw1, 1);
        to_drive();
        to_sample();
        chk("wide_alone_rsp_off", rspw1, 0);
        to_drive();

        // Starvation: stall climbs to 8, then a 4-grant wide burst
        wide_req_i   = 1'b1;
        narrow_req_i = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            to_sample();
            chk("starve_stall", stall1, k);
            chk("starve_prio", prio1, 0);
            chk("starve_wgnt", wgnt1, 0);
            chk("starve_ngnt", ngnt1, 4'b0001);
            to_drive();
        end
        for (int j = 0; j < 4; j++) begin
            to_sample();
            chk("burst_prio", prio1, 1);
            chk("burst_wgnt", wgnt1, 1);
            chk("burst_ngnt", ngnt1, 0);
            chk("burst_stall", stall1, (j == 0) ? 8 : 0);
            to_drive();
        end
        // Back in narrow priority; the stall count restarts from zero
        for (int k = 0; k < 8; k++) begin
            to_sample();
            chk("restall_stall", stall1, k);
            chk("restall_prio", prio1, 0);
            chk("restall_ngnt", ngnt1, 4'b0001);
            to_drive();
        end
        for (int j = 0; j < 2; j++) begin
            to_sample();
            chk("early_prio", prio1, 1);
            chk("early_wgnt", wgnt1, 1);
            to_drive();
        end
        // Early exit when the wide requester goes away
        wide_req_i = 1'b0;
        to_sample();
        chk("early_drop_prio", prio1, 1);
        chk("early_drop_ngnt", ngnt1, 0);
        chk("early_drop_wgnt", wgnt1, 0);
        chk("early_drop_rspw", rspw1, 1);
        to_drive();
        to_sample();
        chk("early_exit_prio", prio1, 0);
        chk("early_exit_ngnt", ngnt1, 4'b0001);
        chk("early_exit_stall", stall1, 0);
        chk("early_exit_rspw", rspw1, 0);
        to_drive();

        // Reset while a wide grant is in flight
        wide_req_i = 1'b1;
        for (int k = 0; k < 8; k++) to_drive();
        rst_ni = 1'b0;
        to_sample();
        chk("rstmid_prio_before", prio1, 1);
        chk("rstmid_wgnt_before", wgnt1, 1);
        to_drive();
        rst_ni       = 1'b1;
        wide_req_i   = 1'b0;
        narrow_req_i = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            chk("rstmid_prio", prio1, 0);
            chk("rstmid_stall", stall1, 0);
            chk("rstmid_rspw", rspw1, 0);
            chk("rstmid_rspw_lat3", rspw3, 0);
            to_drive();
        end

        // Wide grant on the cycle the stall would saturate: clear wins
        wide_req_i   = 1'b1;
        narrow_req_i = 4'b0001;
        for (int k = 0; k < 7; k++) to_drive();
        narrow_req_i = 4'b0000;
        to_sample();
        chk("sat_race_stall", stall1, 7);
        chk("sat_race_wgnt", wgnt1, 1);
        to_drive();
        wide_req_i = 1'b0;
        to_sample();
        chk("sat_race_prio", prio1, 0);
        chk("sat_race_stall_clr", stall1, 0);
        to_drive();

        // Random phase against a reference model
        rst_ni = 1'b0;
        to_drive();
        rst_ni  = 1'b1;
        m_wide  = 1'b0;
        m_stall = '0;
        m_burst = '0;
        h1      = '0;
        for (int i = 0; i < 3; i++) h3[i] = '0;
        for (int c = 0; c < 10000; c++) begin
            wide_req_i   = ($urandom_range(0, 9) != 0);
            narrow_req_i = 4'($urandom_range(0, 15));
            to_sample();
            m_ng = m_wide ? 4'b0000 : narrow_req_i;
            m_wg = m_wide ? wide_req_i : (wide_req_i && narrow_req_i == 4'b0000);
            chk("rnd_ngnt", ngnt1, m_ng);
            chk("rnd_wgnt", wgnt1, m_wg);
            chk("rnd_prio", prio1, m_wide);
            chk("rnd_stall", stall1, m_stall);
            chk("rnd_excl", {wgnt1 && (ngnt1 != 0), wgnt0 && (ngnt0 != 0), wgnt3 && (ngnt3 != 0)}, 0);
            chk("rnd_rsp_lat0", {rspw0, rspn0}, {wgnt0, ngnt0});
            chk("rnd_rsp_lat1", {rspw1, rspn1}, h1);
            chk("rnd_rsp_lat3", {rspw3, rspn3}, h3[2]);
            h1    = {wgnt1, ngnt1};
            h3[2] = h3[1];
            h3[1] = h3[0];
            h3[0] = {wgnt3, ngnt3};
            // Advance the model across the coming edge
            m_stall_n = m_wg ? 8'd0 : (wide_req_i && m_stall < 8'd8) ? m_stall + 8'd1 : m_stall;
            m_burst_n = m_burst;
            if (!m_wide) begin
                if (m_stall_n == 8'd8) begin
                    m_wide    = 1'b1;
                    m_burst_n = 8'd0;
                end
            end else begin
                if (m_wg) m_burst_n = m_burst + 8'd1;
                if (!wide_req_i || m_burst_n == 8'd4) begin
                    m_wide    = 1'b0;
                    m_stall_n = 8'd0;
                end
            end
            m_stall = m_stall_n;
            m_burst = m_burst_n;
            to_drive();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bank_group_arbiter.md
MEM_BANK_GROUP_ARBITER -- requirements
Module: mem_bank_group_arbiter

Interface
REQ-001: Parameter NumNarrowPerWide, default 4: number of narrow banks covered by one wide bank; power of 2, at least 2.
REQ-002: Parameter MaxWideStall, default 8: number of stalled cycles after which wide access gets priority; range 1..255.
REQ-003: Parameter MaxWideBurst, default 4: maximum consecutive wide grants while in wide priority; range 1..255.
REQ-004: Parameter RespLat, default 1: bank response latency in cycles, counted from grant to response-select valid; range 0..8.
REQ-005: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006: rst_ni  input  1  reset; synchronous and active-low.
REQ-007: narrow_req_i  input  NumNarrowPerWide  per-bank narrow request valid.
REQ-008: narrow_gnt_o  output  NumNarrowPerWide  per-bank narrow grant (ready).
REQ-009: wide_req_i  input  1  wide request valid; the request spans all NumNarrowPerWide banks.
REQ-010: wide_gnt_o  output  1  wide grant (ready).
REQ-011: rsp_narrow_valid_o  output  NumNarrowPerWide  per bank: a narrow grant occurred RespLat cycles earlier.
REQ-012: rsp_wide_valid_o  output  1  a wide grant occurred RespLat cycles earlier; selects the wide response path at the bank mux.
REQ-013: wide_prio_o  output  1  high while the FSM is in the WIDE_PRIO state.
REQ-014: stall_cnt_o  output  8  current wide-stall counter value, for debug.

Function
REQ-015: The FSM SHALL have two states, NARROW_PRIO and WIDE_PRIO, with NARROW_PRIO as the reset state.
REQ-016: In NARROW_PRIO, narrow_gnt_o SHALL equal narrow_req_i, and wide_gnt_o SHALL equal wide_req_i AND (narrow_req_i == 0).
REQ-017: In WIDE_PRIO, wide_gnt_o SHALL equal wide_req_i and narrow_gnt_o SHALL be all 0.
REQ-018: A wide grant and any narrow grant SHALL never be asserted in the same cycle.
REQ-019: Grants SHALL be combinational from the requests and the registered state, with zero added latency.
REQ-020: The stall counter SHALL be updated each cycle as follows:
- +1 (saturating at MaxWideStall) when wide_req_i=1 and wide_gnt_o=0;
- cleared to 0 when wide_gnt_o=1;
- unchanged when wide_req_i=0.
REQ-021: The transition NARROW_PRIO -> WIDE_PRIO SHALL occur at the clock edge where the stall counter's next value equals MaxWideStall.
REQ-022: The burst counter SHALL clear on entry to WIDE_PRIO and increment on each wide grant in WIDE_PRIO.
REQ-023: The transition WIDE_PRIO -> NARROW_PRIO SHALL occur when the burst counter reaches MaxWideBurst, or in any WIDE_PRIO cycle with wide_req_i=0; in both cases the stall counter clears.
REQ-024: If a wide grant occurs in the same cycle the stall counter would reach MaxWideStall, the clear SHALL take precedence and no transition occurs.
REQ-025: rsp_narrow_valid_o and rsp_wide_valid_o SHALL be the corresponding grants delayed by exactly RespLat cycles through a shift register; with RespLat=0 they are combinational copies of the grants.
REQ-026: Requests without grants SHALL produce no response valid.
REQ-027: The block SHALL hold no request payload; handshake is valid/ready per cycle, and a requester holds its request until granted.

Reset
REQ-028: While rst_ni=0 at a clock edge, the following SHALL all be cleared: FSM to NARROW_PRIO, stall and burst counters to 0, all response shift-register stages to 0.
REQ-029: Registered outputs SHALL reset to rsp_narrow_valid_o=0, rsp_wide_valid_o=0, wide_prio_o=0, stall_cnt_o=0; grants then follow REQ-016 with the reset state.
REQ-030: A reset asserted mid-burst or mid-latency SHALL discard all in-flight response valids, with no valid pulse after reset release.

Verification
REQ-031: Idle narrow traffic: narrow_req_i=4'b0101, wide_req_i=0 -> narrow_gnt_o=4'b0101 in the same cycle; rsp_narrow_valid_o=4'b0101 exactly 1 cycle later.
REQ-032: Wide alone: wide_req_i=1, narrow_req_i=0 -> wide_gnt_o=1 every cycle, stall_cnt_o stays 0, wide_prio_o stays 0.
REQ-033: Starvation: wide_req_i=1 with narrow_req_i=4'b0001 held continuously -> stall_cnt_o counts 1..8; wide_prio_o=1 from cycle 9; wide_gnt_o=1 and narrow_gnt_o=0 for 4 cycles; then back to NARROW_PRIO.
REQ-034: Early exit: in WIDE_PRIO after 2 wide grants, drop wide_req_i -> return to NARROW_PRIO the next cycle; narrow_gnt_o follows narrow_req_i again.
REQ-035: Reset mid-operation: assert rst_ni=0 for 1 cycle while in WIDE_PRIO with a wide grant in flight -> wide_prio_o=0, stall_cnt_o=0, and no rsp_wide_valid_o pulse afterwards.
REQ-036: Exclusivity: random requests over 10k cycles with RespLat in {0,3} -> an assertion confirms wide and narrow grants never overlap, and each response valid matches its grant delayed by RespLat.
